// File: rtl/uart_defs.sv
`default_nettype none
// ============================================================================
// Module  : uart_defs
// Brief   : Shared constants and FSM encoding for the UART transmit queue.
// Rev     : 1.0
// ============================================================================
package uart_defs;

    localparam int c_DATA_W = 8;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_LOAD = 2'd1;
    localparam logic [1:0] c_ST_ARM  = 2'd2;
    localparam logic [1:0] c_ST_WAIT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = c_ST_IDLE,
        ST_LOAD = c_ST_LOAD,
        ST_ARM  = c_ST_ARM,
        ST_WAIT = c_ST_WAIT
    } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_txq_if.sv
`default_nettype none
// ============================================================================
// Module  : uart_txq_if
// Brief   : Host-side write port and uartICE40-side load/busy bundle.
// Rev     : 1.0
// ============================================================================
interface uart_txq_if #(
    parameter int AW = 4
);
    import uart_defs::*;

    logic                wr;
    logic [c_DATA_W-1:0] wdata;
    logic                full;
    logic                empty;
    logic [AW:0]         level;
    logic                ovf;
    logic                ovf_clr;
    logic                load;
    logic [c_DATA_W-1:0] d;
    logic                txbusy;

    modport master (
        output wr, wdata, ovf_clr, txbusy,
        input  full, empty, level, ovf, load, d
    );

    modport slave (
        input  wr, wdata, ovf_clr, txbusy,
        output full, empty, level, ovf, load, d
    );

endinterface
`default_nettype wire

// File: rtl/uart_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module  : uart_fifo_ram
// Brief   : 2^AW x 8 storage, synchronous write, asynchronous (LUT) read.
// Rev     : 1.0
// ============================================================================
module uart_fifo_ram
    import uart_defs::*;
#(
    parameter int AW = 4
) (
    input  wire logic                clk,
    input  wire logic                i_we,
    input  wire logic [AW-1:0]       i_waddr,
    input  wire logic [c_DATA_W-1:0] i_wdata,
    input  wire logic [AW-1:0]       i_raddr,
    output logic      [c_DATA_W-1:0] o_rdata
);

    logic [c_DATA_W-1:0] r_mem [2**AW];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/uart_txq.sv
`default_nettype none
// ============================================================================
// Module  : uart_txq
// Brief   : Byte FIFO feeding uartICE40 load/d, one pop per idle transmitter.
// Rev     : 1.0
// ============================================================================
module uart_txq
    import uart_defs::*;
#(
    parameter int AW = 4
) (
    input  wire logic   clk,
    input  wire logic   rst,
    uart_txq_if.slave   bus
);

    localparam logic [AW:0] c_DEPTH = {1'b1, {AW{1'b0}}};

    logic [AW:0]         r_wptr;
    logic [AW:0]         r_rptr;
    logic [AW:0]         w_level;
    logic                w_full;
    logic                w_empty;
    logic                w_wr_ok;
    logic                w_pop;
    logic [c_DATA_W-1:0] w_head;
    logic [c_DATA_W-1:0] r_d;
    logic                r_ovf;
    state_t              r_state;
    state_t              w_state_nxt;

    assign w_level = r_wptr - r_rptr;
    assign w_full  = (w_level == c_DEPTH);
    assign w_empty = (w_level == '0);

    // Full is judged before any same-cycle pop, so a write into a full queue
    // is always dropped even when a slot is being freed.
    assign w_wr_ok = bus.wr && !w_full;
    assign w_pop   = (r_state == ST_IDLE) && !w_empty && !bus.txbusy;

    uart_fifo_ram #(
        .AW (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_ok),
        .i_waddr (r_wptr[AW-1:0]),
        .i_wdata (bus.wdata),
        .i_raddr (r_rptr[AW-1:0]),
        .o_rdata (w_head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_d    <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
                r_d    <= w_head;
            end
            if (bus.wr && w_full) begin
                r_ovf <= 1'b1;
            end else if (bus.ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ARM masks txbusy for one cycle while the transmitter registers its busy rise.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_pop)        w_state_nxt = ST_LOAD;
            ST_LOAD:                   w_state_nxt = ST_ARM;
            ST_ARM:                    w_state_nxt = ST_WAIT;
            ST_WAIT: if (!bus.txbusy)  w_state_nxt = ST_IDLE;
            default:                   w_state_nxt = ST_IDLE;
        endcase
    end

    assign bus.full  = w_full;
    assign bus.empty = w_empty;
    assign bus.level = w_level;
    assign bus.ovf   = r_ovf;
    assign bus.load  = (r_state == ST_LOAD);
    assign bus.d     = r_d;

endmodule
`default_nettype wire

// File: tb/tb_uart_txq.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_txq
// Brief   : Directed bench for uart_txq with a behavioural uartICE40 stand-in.
// Rev     : 1.0
// ============================================================================
module tb_uart_txq;
    import uart_defs::*;

    localparam int AW   = 2;
    localparam int CHAR = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_txq_if #(.AW(AW)) bus();

    uart_txq #(
        .AW (AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] rx_q[$];
    int         cnt = 0;
    bit         arm_pending = 1'b0;
    bit         force_busy  = 1'b0;
    int         cyc = 0;
    int         last_load = -100;

    // Transmitter stand-in: busy rises one cycle after load, lasts CHAR cycles.
    initial begin
        bus.txbusy = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.load === 1'b1) begin
                n_checks++;
                if (bus.txbusy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL load_while_busy: load=1 with txbusy=%b, required txbusy=0", bus.txbusy);
                end
                n_checks++;
                if (cyc - last_load < 4) begin
                    n_fail++;
                    $display("FAIL load_spacing: spacing %0d cycles, required >= 4", cyc - last_load);
                end
                last_load = cyc;
                rx_q.push_back(bus.d);
            end
            if (arm_pending) begin
                cnt = CHAR;
                arm_pending = 1'b0;
            end else if (cnt > 0) begin
                cnt--;
            end
            if (bus.load === 1'b1) arm_pending = 1'b1;
            bus.txbusy = force_busy || (cnt > 0);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        bus.wr    = 1'b1;
        bus.wdata = b;
        tick();
        bus.wr    = 1'b0;
    endtask

    task automatic drain(input int n);
        int guard;
        guard = 0;
        while (!(rx_q.size() >= n && !bus.txbusy && cnt == 0 && !arm_pending &&
                 bus.empty && !bus.load) && guard < 500) begin
            tick();
            guard++;
        end
        n_checks++;
        if (guard >= 500) begin
            n_fail++;
            $display("FAIL drain_timeout: received %0d bytes, required %0d", rx_q.size(), n);
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++; if (bus.load !== 1'b0)  begin n_fail++; $display("FAIL reset_load: got %b required 0", bus.load); end
        n_checks++; if (bus.d !== 8'h00)    begin n_fail++; $display("FAIL reset_d: got %h required 00", bus.d); end
        n_checks++; if (bus.full !== 1'b0)  begin n_fail++; $display("FAIL reset_full: got %b required 0", bus.full); end
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b required 1", bus.empty); end
        n_checks++; if (bus.level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d required 0", bus.level); end
        n_checks++; if (bus.ovf !== 1'b0)   begin n_fail++; $display("FAIL reset_ovf: got %b required 0", bus.ovf); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        rx_q.delete();
        write_byte(8'hC1);
        n_checks++; if (bus.level !== 3'd1) begin n_fail++; $display("FAIL single_level1: got %0d required 1", bus.level); end
        n_checks++; if (bus.empty !== 1'b0) begin n_fail++; $display("FAIL single_empty: got %b required 0", bus.empty); end
        n_checks++; if (bus.load !== 1'b0)  begin n_fail++; $display("FAIL single_early_load: got %b required 0", bus.load); end
        tick();
        n_checks++; if (bus.load !== 1'b1)  begin n_fail++; $display("FAIL single_load: got %b required 1", bus.load); end
        n_checks++; if (bus.d !== 8'hC1)    begin n_fail++; $display("FAIL single_d: got %h required c1", bus.d); end
        n_checks++; if (bus.level !== 3'd0) begin n_fail++; $display("FAIL single_level0: got %0d required 0", bus.level); end
        tick();
        n_checks++; if (bus.load !== 1'b0)  begin n_fail++; $display("FAIL single_load_width: got %b required 0", bus.load); end
        drain(1);
        n_checks++; if (rx_q.size() !== 1 || rx_q[0] !== 8'hC1) begin n_fail++; $display("FAIL single_rx: got %0d bytes first %h required 1 byte c1", rx_q.size(), rx_q[0]); end
    endtask

    task automatic test_burst();
        logic [7:0] exp [3];
        exp = '{8'hC1, 8'h4E, 8'h55};
        rx_q.delete();
        force_busy = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) write_byte(exp[i]);
        n_checks++; if (bus.level !== 3'd3) begin n_fail++; $display("FAIL burst_level: got %0d required 3", bus.level); end
        force_busy = 1'b0;
        drain(3);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (rx_q.size() <= i || rx_q[i] !== exp[i]) begin n_fail++; $display("FAIL burst_rx%0d: got %h required %h", i, (rx_q.size() > i) ? rx_q[i] : 8'hxx, exp[i]); end
        end
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL burst_empty: got %b required 1", bus.empty); end
    endtask

    task automatic test_fill();
        rx_q.delete();
        force_busy = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) write_byte(8'hA0 + 8'(i));
        n_checks++; if (bus.full !== 1'b1)  begin n_fail++; $display("FAIL fill_full: got %b required 1", bus.full); end
        n_checks++; if (bus.level !== 3'd4) begin n_fail++; $display("FAIL fill_level4: got %0d required 4", bus.level); end
        n_checks++; if (bus.ovf !== 1'b0)   begin n_fail++; $display("FAIL fill_ovf_early: got %b required 0", bus.ovf); end
        write_byte(8'hA4);
        n_checks++; if (bus.ovf !== 1'b1)   begin n_fail++; $display("FAIL fill_ovf: got %b required 1", bus.ovf); end
        n_checks++; if (bus.level !== 3'd4) begin n_fail++; $display("FAIL fill_level_drop: got %0d required 4", bus.level); end
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        n_checks++; if (bus.ovf !== 1'b0)   begin n_fail++; $display("FAIL fill_ovf_clr: got %b required 0", bus.ovf); end
        bus.ovf_clr = 1'b1;
        write_byte(8'hA5);
        bus.ovf_clr = 1'b0;
        n_checks++; if (bus.ovf !== 1'b1)   begin n_fail++; $display("FAIL fill_set_wins: got %b required 1", bus.ovf); end
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        force_busy = 1'b0;
        drain(4);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rx_q.size() <= i || rx_q[i] !== 8'hA0 + 8'(i)) begin n_fail++; $display("FAIL fill_rx%0d: got %h required %h", i, (rx_q.size() > i) ? rx_q[i] : 8'hxx, 8'hA0 + 8'(i)); end
        end
        n_checks++; if (rx_q.size() !== 4) begin n_fail++; $display("FAIL fill_rx_count: got %0d required 4", rx_q.size()); end
    endtask

    task automatic test_simul();
        rx_q.delete();
        force_busy = 1'b1;
        tick();
        write_byte(8'h11);
        n_checks++; if (bus.level !== 3'd1) begin n_fail++; $display("FAIL simul_pre_level: got %0d required 1", bus.level); end
        force_busy = 1'b0;
        tick();
        write_byte(8'h22);
        n_checks++; if (bus.level !== 3'd1) begin n_fail++; $display("FAIL simul_level: got %0d required 1", bus.level); end
        n_checks++; if (bus.load !== 1'b1)  begin n_fail++; $display("FAIL simul_load: got %b required 1", bus.load); end
        n_checks++; if (bus.d !== 8'h11)    begin n_fail++; $display("FAIL simul_d: got %h required 11", bus.d); end
        drain(2);
        n_checks++; if (rx_q.size() !== 2 || rx_q[0] !== 8'h11 || rx_q[1] !== 8'h22) begin n_fail++; $display("FAIL simul_order: got %0d bytes, required 11 then 22", rx_q.size()); end
    endtask

    task automatic test_wrap();
        int idx;
        int guard;
        rx_q.delete();
        idx = 0;
        guard = 0;
        while (idx < 40 && guard < 3000) begin
            if (!bus.full) begin
                bus.wr    = 1'b1;
                bus.wdata = 8'(idx);
                idx++;
            end else begin
                bus.wr = 1'b0;
            end
            tick();
            guard++;
        end
        bus.wr = 1'b0;
        n_checks++;
        if (guard >= 3000) begin n_fail++; $display("FAIL wrap_timeout: wrote %0d bytes, required 40", idx); end
        drain(40);
        n_checks++; if (rx_q.size() !== 40) begin n_fail++; $display("FAIL wrap_count: got %0d required 40", rx_q.size()); end
        for (int i = 0; i < 40; i++) begin
            n_checks++;
            if (rx_q.size() <= i || rx_q[i] !== 8'(i)) begin n_fail++; $display("FAIL wrap_rx%0d: got %h required %h", i, (rx_q.size() > i) ? rx_q[i] : 8'hxx, 8'(i)); end
        end
        n_checks++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL wrap_ovf: got %b required 0", bus.ovf); end
    endtask

    task automatic test_reset_mid();
        int guard;
        rx_q.delete();
        for (int i = 0; i < 4; i++) write_byte(8'h31 + 8'(i));
        guard = 0;
        while (!(bus.level == 3'd3 && bus.txbusy) && guard < 50) begin
            tick();
            guard++;
        end
        n_checks++;
        if (guard >= 50) begin n_fail++; $display("FAIL rstmid_setup: level %0d txbusy %b, required 3 and 1", bus.level, bus.txbusy); end
        rst = 1'b1;
        #1;
        n_checks++; if (bus.load !== 1'b0)  begin n_fail++; $display("FAIL rstmid_load: got %b required 0", bus.load); end
        n_checks++; if (bus.d !== 8'h00)    begin n_fail++; $display("FAIL rstmid_d: got %h required 00", bus.d); end
        n_checks++; if (bus.level !== 3'd0) begin n_fail++; $display("FAIL rstmid_level: got %0d required 0", bus.level); end
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL rstmid_empty: got %b required 1", bus.empty); end
        n_checks++; if (bus.full !== 1'b0)  begin n_fail++; $display("FAIL rstmid_full: got %b required 0", bus.full); end
        tick();
        rst = 1'b0;
        write_byte(8'h5A);
        drain(2);
        n_checks++; if (rx_q.size() !== 2 || rx_q[0] !== 8'h31 || rx_q[1] !== 8'h5A) begin n_fail++; $display("FAIL rstmid_rx: got %0d bytes, required 31 then 5a", rx_q.size()); end
    endtask

    initial begin
        rst         = 1'b1;
        bus.wr      = 1'b0;
        bus.wdata   = 8'h00;
        bus.ovf_clr = 1'b0;
        test_reset();
        test_single();
        test_burst();
        test_fill();
        test_simul();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/uart_txq.md
# uart_txq

Transmit queue that sits directly upstream of the `uartICE40` transmitter and drives its `load`/`d` inputs. It buffers bytes written by the host logic in a power-of-two FIFO. It pops one byte at a time into the UART whenever the transmitter reports idle via `txbusy`. The host can therefore burst writes without tracking character timing. Runs in the UART's transmit clock domain.

## Interface
Parameters:
- `AW`, 4, FIFO address width; depth = 2^AW entries (AW ≥ 1).

Ports:
- `clk`  in  1  UART transmit clock, same clock as the downstream `uartICE40` (all logic on rising edge).
- `rst`  in  1  Asynchronous, active-high reset.
- `wr`  in  1  Write strobe, one byte per cycle.
- `wdata`  in  8  Byte to enqueue, sampled when `wr`=1.
- `full`  out  1  FIFO holds 2^AW entries.
- `empty`  out  1  FIFO holds 0 entries.
- `level`  out  AW+1  Current entry count, 0..2^AW.
- `ovf`  out  1  Sticky overflow flag: a write was attempted while full.
- `ovf_clr`  in  1  Clears `ovf`.
- `load`  out  1  Single-cycle load pulse to `uartICE40.load`.
- `d`  out  8  Byte to `uartICE40.d`; stable from the `load` cycle until `txbusy` is observed low again.
- `txbusy`  in  1  From `uartICE40.txbusy`.

## Operation
- FIFO: write pointer and read pointer, each AW+1 bits, wrap naturally. `level` = wptr − rptr (mod 2^(AW+1)). `full` = (level == 2^AW). `empty` = (level == 0). All three are registered or derived from registered pointers.
- Write with `full`=1: data dropped, pointers unchanged, `ovf` set next cycle. `ovf_clr` and an overflowing write in the same cycle: set wins.
- Simultaneous write and pop:
  - Not full: both happen; `level` unchanged.
  - Full: the pop frees a slot, but the write is still dropped and flagged as overflow, because `full` is evaluated before the pop.
- The pop happens in the cycle `load`=1. `d` is loaded from the FIFO head at the same edge that raises `load`.
- FSM states:
  - IDLE: when `!empty && !txbusy`, go to LOAD. The byte is popped, `d` is registered, and `load`=1 for exactly that cycle.
  - LOAD: go to ARM unconditionally. `load` returns to 0.
  - ARM: `txbusy` is ignored for one cycle to cover the transmitter's registered busy rise; go to WAIT.
  - WAIT: stay while `txbusy`=1. When `txbusy`=0, go to IDLE.
- Back-to-back bytes: from WAIT exit, the next `load` issues one cycle later (IDLE→LOAD) if the FIFO is not empty.
- Reset values: `load`=0, `d`=8'h00, `full`=0, `empty`=1, `level`=0, `ovf`=0, FSM=IDLE, pointers=0.
- Reset mid-transmission: queue contents are discarded. The in-flight UART character is not aborted; the block returns to IDLE and waits for `txbusy`=0 before issuing another load.

## Timing
- Write into an empty FIFO while IDLE and `txbusy`=0:
  - `wr`=1 at edge k.
  - `empty`=0 and `level`=1 after edge k.
  - `load`=1 after edge k+1, with `level` back to 0 after the same edge.
- Write-to-load latency: 2 cycles.
- Minimum spacing between `load` pulses: 4 cycles (LOAD, ARM, ≥1 WAIT, IDLE). The actual spacing is set by `txbusy`, i.e. one full character time.
- `full`, `empty` and `level` update on the edge after `wr` or the pop.

## Structure
- Shared package/include `uart_defs`: FSM state encoding (IDLE, LOAD, ARM, WAIT as 2-bit localparams). The 8-bit data width constant also belongs there.
- Sub-module `uart_fifo_ram`: 2^AW×8 storage with synchronous write and asynchronous (LUT) read, mappable to iCE40 logic. Instantiated once.
- Pointer arithmetic, flags and FSM live in `uart_txq`.

## Test plan
- Single byte: reset, write 8'hC1 with `uartICE40` connected and looped to a receiver → one `load` 2 cycles after `wr`; receiver `q`=8'hC1.
- Burst: write 8'hC1, 8'h4E, 8'h55 on consecutive cycles → `level` reaches 3. Three loads occur, each only after `txbusy` falls; received in order C1, 4E, 55. `empty`=1 at end.
- Fill: with AW=2, write 5 bytes while `txbusy` is held high → `full`=1 after the 4th write; 5th dropped; `ovf`=1; `level`=4. Pulse `ovf_clr` → `ovf`=0.
- Simultaneous write and pop with `level`=1 → `level` stays 1, FIFO order preserved.
- Pointer wrap: stream 40 bytes 8'h00..8'h27 with AW=2 → all received in order, no `ovf`.
- Reset mid-stream: assert `rst` while `level`=3 during a character → all outputs at reset values immediately; no `load` until `txbusy` falls.
